// File: rtl/bot_disp_sync.sv
// bot_disp_sync: shadow-buffers Rojobot location/info updates and commits them to the
// display-side registers only on vertical-blanking entry, so the icon never tears mid-frame.
module bot_disp_sync #(
  parameter logic [9:0] VBLANK_ROW = 10'd480,
  parameter logic [7:0] RST_LOCX   = 8'd64,
  parameter logic [7:0] RST_LOCY   = 8'd64,
  parameter int unsigned DROP_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              upd_sysregs,
  input  logic [7:0]        locx_in,
  input  logic [7:0]        locy_in,
  input  logic [7:0]        botinfo_in,
  input  logic [9:0]        pixel_row,
  output logic [7:0]        locx_reg,
  output logic [7:0]        locy_reg,
  output logic [7:0]        botinfo_reg,
  output logic              upd_pending,
  output logic              frame_tick,
  output logic [DROP_W-1:0] drop_cnt
);
  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;
  state_t            state_q;
  logic [7:0]        locx_q, locy_q, info_q, sh_locx_q, sh_locy_q, sh_info_q;
  logic              pend_q, tick_q, in_vblank_q;
  logic [DROP_W-1:0] drop_q;
  logic              in_vblank, vblank_rise;
  assign in_vblank   = pixel_row >= VBLANK_ROW;
  assign vblank_rise = in_vblank & ~in_vblank_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      locx_q      <= RST_LOCX;
      locy_q      <= RST_LOCY;
      info_q      <= '0;
      sh_locx_q   <= RST_LOCX;
      sh_locy_q   <= RST_LOCY;
      sh_info_q   <= '0;
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
      in_vblank_q <= 1'b1;
      drop_q      <= '0;
    end else begin
      in_vblank_q <= in_vblank;
      tick_q      <= vblank_rise;
      case (state_q)
        IDLE:
          if (upd_sysregs) begin
            {sh_locx_q, sh_locy_q, sh_info_q} <= {locx_in, locy_in, botinfo_in};
            pend_q  <= 1'b1;
            state_q <= PEND;
          end
        PEND: begin
          if (upd_sysregs) begin
            {sh_locx_q, sh_locy_q, sh_info_q} <= {locx_in, locy_in, botinfo_in};
            if (drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + 1'b1;
          end
          if (vblank_rise) state_q <= COMMIT;
        end
        COMMIT: begin
          // commit takes the old shadow; a same-cycle update waits for next frame
          {locx_q, locy_q, info_q} <= {sh_locx_q, sh_locy_q, sh_info_q};
          if (upd_sysregs) begin
            {sh_locx_q, sh_locy_q, sh_info_q} <= {locx_in, locy_in, botinfo_in};
            state_q <= PEND;
          end else begin
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign locx_reg    = locx_q;
  assign locy_reg    = locy_q;
  assign botinfo_reg = info_q;
  assign upd_pending = pend_q;
  assign frame_tick  = tick_q;
  assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_bot_disp_sync.sv
// tb_bot_disp_sync: directed vectors with hand-computed expectations for bot_disp_sync.
module tb_bot_disp_sync;
  logic       clk = 1'b0, reset_n = 1'b0, upd = 1'b0;
  logic [7:0] lx = '0, ly = '0, bi = '0;
  logic [9:0] row = 10'd100;
  logic [7:0] locx_reg, locy_reg, botinfo_reg, drop_cnt;
  logic       upd_pending, frame_tick;
  int total = 0, bad = 0;
  bot_disp_sync dut (
    .clk(clk), .reset_n(reset_n), .upd_sysregs(upd), .locx_in(lx), .locy_in(ly),
    .botinfo_in(bi), .pixel_row(row), .locx_reg(locx_reg), .locy_reg(locy_reg),
    .botinfo_reg(botinfo_reg), .upd_pending(upd_pending), .frame_tick(frame_tick),
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic post(input logic [7:0] x, input logic [7:0] y, input logic [7:0] b);
    upd = 1'b1; lx = x; ly = y; bi = b;
    tick();
    upd = 1'b0;
  endtask
  task automatic frame();
    row = 10'd480;
    tick();
    chk("tick_on", 32'(frame_tick), 1);
    tick();
    chk("tick_off", 32'(frame_tick), 0);
    row = 10'd10;
    tick();
  endtask
  task automatic outs(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [7:0] b);
    chk({tag, "_x"}, 32'(locx_reg), 32'(x));
    chk({tag, "_y"}, 32'(locy_reg), 32'(y));
    chk({tag, "_b"}, 32'(botinfo_reg), 32'(b));
  endtask
  initial begin
    repeat (3) tick();
    outs("rst", 8'd64, 8'd64, 8'd0);
    chk("rst_pend", 32'(upd_pending), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_tick", 32'(frame_tick), 0);
    end
    post(8'd10, 8'd20, 8'd3);
    chk("p1_pend", 32'(upd_pending), 1);
    row = 10'd479;
    tick();
    chk("row479_tick", 32'(frame_tick), 0);
    row = 10'd480;
    tick();
    chk("p1_tick", 32'(frame_tick), 1);
    chk("p1_hold_x", 32'(locx_reg), 64);
    chk("p1_hold_pend", 32'(upd_pending), 1);
    tick();
    outs("p1", 8'd10, 8'd20, 8'd3);
    chk("p1_tick_off", 32'(frame_tick), 0);
    chk("p1_pend_clr", 32'(upd_pending), 0);
    row = 10'd10;
    tick();
    post(8'd5, 8'd5, 8'd1);
    post(8'd7, 8'd8, 8'd2);
    outs("p2_hold", 8'd10, 8'd20, 8'd3);
    frame();
    outs("p2", 8'd7, 8'd8, 8'd2);
    chk("p2_drop", 32'(drop_cnt), 1);
    chk("p2_pend", 32'(upd_pending), 0);
    post(8'd1, 8'd1, 8'd1);
    row = 10'd480;
    post(8'd33, 8'd34, 8'd4);
    tick();
    outs("p3", 8'd33, 8'd34, 8'd4);
    chk("p3_drop", 32'(drop_cnt), 2);
    chk("p3_pend", 32'(upd_pending), 0);
    row = 10'd10;
    tick();
    post(8'd40, 8'd41, 8'd5);
    row = 10'd480;
    tick();
    post(8'd50, 8'd51, 8'd6);
    outs("p4_old", 8'd40, 8'd41, 8'd5);
    chk("p4_pend", 32'(upd_pending), 1);
    chk("p4_drop", 32'(drop_cnt), 2);
    tick();
    chk("p4_inblank_x", 32'(locx_reg), 40);
    row = 10'd10;
    tick();
    frame();
    outs("p4_new", 8'd50, 8'd51, 8'd6);
    chk("p4_pend_clr", 32'(upd_pending), 0);
    upd = 1'b1; lx = 8'd99; ly = 8'd98; bi = 8'd7;
    for (int i = 0; i < 300; i++) tick();
    chk("sat_drop", 32'(drop_cnt), 255);
    repeat (5) tick();
    upd = 1'b0;
    chk("sat_hold", 32'(drop_cnt), 255);
    chk("sat_pend", 32'(upd_pending), 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    outs("arst", 8'd64, 8'd64, 8'd0);
    chk("arst_drop", 32'(drop_cnt), 0);
    chk("arst_pend", 32'(upd_pending), 0);
    tick();
    reset_n = 1'b1;
    tick();
    frame();
    outs("no_stale", 8'd64, 8'd64, 8'd0);
    chk("no_stale_pend", 32'(upd_pending), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
